div_unit: RTL

- Multi-cycle iterative divider for the EX stage. It serves DIV/DIVU and writes to HI/LO through the existing ex -> ex_mem -> mem_wb -> hilo enable path.
- Radix-2 restoring division, one quotient bit per clock, width parametrised.
- EX stalls on busy_o. The pipeline cancels an in-flight divide with annul_i on flush.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit_step.sv | 19 +
 rtl/div_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and handshake levels.
// The DIV_EARLY_OUT_EN macro adds the DivEarly state for the short-dividend path.
package div_unit_pkg;

  typedef enum logic [2:0] {
    DivFree   = 3'd0,
    DivByZero = 3'd1,
    DivOn     = 3'd2,
    DivEnd    = 3'd3
`ifdef DIV_EARLY_OUT_EN
    , DivEarly  = 3'd4
`endif
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake bundle. master = EX stage, slave = div_unit.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor always holds, so diff fits WIDTH+1 bits with its MSB as the sign.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish in one step when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  div_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_mag, op2_mag;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     quo_next;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign op1_mag = cond_neg(bus.opdata1_i, op1_neg);
  assign op2_mag = cond_neg(bus.opdata2_i, op2_neg);

  // dividend_q doubles as the quotient shift register: dividend bits leave at the top,
  // quotient bits enter at the bottom.
  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dividend_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );
  assign quo_next = {dividend_q[WIDTH-2:0], step_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      DivFree: begin
        if (bus.start_i == DivStart && !bus.annul_i) begin
          dividend_d = op1_mag;
          divisor_d  = op2_mag;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quo_d  = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
`ifdef DIV_EARLY_OUT_EN
          end else if (op1_mag < op2_mag) begin
            state_d = DivEarly;
`endif
          end else begin
            state_d = DivOn;
          end
        end
      end
      DivByZero: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
`ifdef DIV_EARLY_OUT_EN
      DivEarly: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = {cond_neg(dividend_q, neg_rem_q), {WIDTH{1'b0}}};
          ready_d  = DivResultReady;
        end
      end
`endif
      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d      = step_rem;
          dividend_d = quo_next;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DivEnd;
            result_d = {cond_neg(step_rem, neg_rem_q), cond_neg(quo_next, neg_quo_q)};
            ready_d  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop || bus.annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end
      end
      default: begin
        state_d = DivFree;
        ready_d = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // ready_q is set exactly when END is entered, so END never contributes to the stall.
  assign bus.busy_o   = (state_q != DivFree) && (state_q != DivEnd);
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;
endmodule
